// File: rtl/wisc_pkg.sv
// Shared ISA constants and the ID/EX control payload for the decode stage.
package wisc_pkg;

  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned OPC_W    = 5;

  localparam logic [OPC_W-1:0] OP_JR   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_JALR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_STU  = 5'b10011;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              link;
    logic [REG_AW-1:0] dst;
  } ex_ctl_t;

  // JAL and JALR both write the return address into the link register.
  function automatic logic is_link_op(input logic [OPC_W-1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/rf_bypass.sv
// 8-entry register file, two combinational reads, one write, optional write-first bypass.
module rf_bypass
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // With FWD_EN a write landing this edge is already visible to the reader.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (FWD_EN && we && (waddr == raddr_a)) rdata_a = wdata;
    if (FWD_EN && we && (waddr == raddr_b)) rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: RF read, field/immediate/target decode, load-use stall, ID/EX register.
module id_stage_pipe
  import wisc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [REG_AW-1:0] LINK_REG = 3'd7,
  parameter bit                FWD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              ctl_reg_dst,
  input  logic              ctl_five_imm,
  input  logic              ctl_zero_ext,
  input  logic              ctl_reg_write,
  input  logic              ctl_mem_read,
  input  logic              ctl_mem_write,
  output logic              id_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_jtarget,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_link,
  output logic              err
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              is_link, is_stu, short_target;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] imm_c, jtarget_c;
  ex_ctl_t           ctl_c;
  ex_ctl_t           ex_ctl_q;
  logic              hazard, stall, accept;

  assign opcode       = if_instr[15:11];
  assign rs           = if_instr[10:8];
  assign rt           = if_instr[7:5];
  assign rd           = if_instr[4:2];
  assign is_link      = is_link_op(opcode);
  assign is_stu       = (opcode == OP_STU);
  assign short_target = (opcode == OP_JR) || (opcode == OP_JALR);

  rf_bypass #(
    .DATA_W (DATA_W),
    .FWD_EN (FWD_EN)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_reg),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Immediate and jump-target extension.
  always_comb begin
    if (ctl_five_imm) begin
      imm_c = ctl_zero_ext ? DATA_W'(if_instr[4:0])
                           : {{(DATA_W-5){if_instr[4]}}, if_instr[4:0]};
    end else begin
      imm_c = ctl_zero_ext ? DATA_W'(if_instr[7:0])
                           : {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]};
    end
    jtarget_c = short_target ? {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]}
                             : {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
  end

  // Destination priority: link, then STU base, then I-format, then R/I select.
  always_comb begin
    ctl_c           = '0;
    ctl_c.reg_write = ctl_reg_write | is_link;
    ctl_c.mem_read  = ctl_mem_read;
    ctl_c.mem_write = ctl_mem_write;
    ctl_c.link      = is_link;
    if (is_link)           ctl_c.dst = LINK_REG;
    else if (is_stu)       ctl_c.dst = rs;
    else if (ctl_five_imm) ctl_c.dst = rt;
    else                   ctl_c.dst = ctl_reg_dst ? rd : rs;
  end

  // Conservative load-use check: both source fields compared whether used or not.
  assign hazard = ex_valid & ex_ctl_q.mem_read & ex_ctl_q.reg_write &
                  ((ex_ctl_q.dst == rs) | (ex_ctl_q.dst == rt));
  assign stall    = ex_valid & ~ex_ready;
  assign id_ready = rst & ~hazard & (~ex_valid | ex_ready);
  assign accept   = if_valid & id_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_jtarget <= '0;
      ex_pc      <= '0;
      ex_ctl_q   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (stall) begin
      ex_valid <= 1'b1;
    end else if (hazard) begin
      ex_valid <= 1'b0;
    end else if (if_valid) begin
      ex_valid   <= 1'b1;
      ex_a       <= rd_a;
      ex_b       <= rd_b;
      ex_imm     <= imm_c;
      ex_jtarget <= jtarget_c;
      ex_pc      <= if_pc;
      ex_ctl_q   <= ctl_c;
    end else begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                                        err <= 1'b0;
    else if (accept & ctl_mem_read & ctl_mem_write)  err <= 1'b1;
  end

  assign ex_dst       = ex_ctl_q.dst;
  assign ex_reg_write = ex_ctl_q.reg_write;
  assign ex_mem_read  = ex_ctl_q.mem_read;
  assign ex_mem_write = ex_ctl_q.mem_write;
  assign ex_link      = ex_ctl_q.link;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions in, ID/EX transfers checked by a monitor.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [15:0] a, b, imm, jt, pc;
    logic [2:0]  dst;
    logic        rw, mr, mw, link;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, wb_we, ex_ready;
  logic [15:0] if_instr, if_pc, wb_data;
  logic [2:0]  wb_reg;
  logic        ctl_reg_dst, ctl_five_imm, ctl_zero_ext, ctl_reg_write, ctl_mem_read, ctl_mem_write;

  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_link, err;
  logic [15:0] ex_a, ex_b, ex_imm, ex_jtarget, ex_pc;
  logic [2:0]  ex_dst;

  logic        id_ready_f0, ex_valid_f0, ex_reg_write_f0, ex_mem_read_f0, ex_mem_write_f0, ex_link_f0, err_f0;
  logic [15:0] ex_a_f0, ex_b_f0, ex_imm_f0, ex_jtarget_f0, ex_pc_f0;
  logic [2:0]  ex_dst_f0;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_act, mon_exp;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(16), .LINK_REG(3'd7), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ctl_reg_dst(ctl_reg_dst), .ctl_five_imm(ctl_five_imm), .ctl_zero_ext(ctl_zero_ext),
    .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
    .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_jtarget(ex_jtarget), .ex_pc(ex_pc), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_link(ex_link), .err(err)
  );

  id_stage_pipe #(.DATA_W(16), .LINK_REG(3'd7), .FWD_EN(1'b0)) dut_f0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ctl_reg_dst(ctl_reg_dst), .ctl_five_imm(ctl_five_imm), .ctl_zero_ext(ctl_zero_ext),
    .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
    .id_ready(id_ready_f0), .flush(flush), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid_f0), .ex_a(ex_a_f0), .ex_b(ex_b_f0), .ex_imm(ex_imm_f0),
    .ex_jtarget(ex_jtarget_f0), .ex_pc(ex_pc_f0), .ex_dst(ex_dst_f0), .ex_reg_write(ex_reg_write_f0),
    .ex_mem_read(ex_mem_read_f0), .ex_mem_write(ex_mem_write_f0), .ex_link(ex_link_f0), .err(err_f0)
  );

  function automatic exp_t mk(input logic [15:0] a, b, imm, jt, pc, input logic [2:0] dst,
                              input logic rw, mr, mw, link);
    exp_t e;
    e = '{a: a, b: b, imm: imm, jt: jt, pc: pc, dst: dst, rw: rw, mr: mr, mw: mw, link: link};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive_phase();
    @(posedge clk);
    #1;
  endtask

  // ctl = {reg_dst, five_imm, zero_ext, reg_write, mem_read, mem_write}
  task automatic set_in(input logic [15:0] instr, input logic [15:0] pc, input logic [5:0] ctl);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    {ctl_reg_dst, ctl_five_imm, ctl_zero_ext, ctl_reg_write, ctl_mem_read, ctl_mem_write} = ctl;
  endtask

  // Present one instruction, push its expected ID/EX image when the stage takes it.
  task automatic issue(input logic [15:0] instr, input logic [15:0] pc, input logic [5:0] ctl,
                       input exp_t e);
    bit done = 1'b0;
    set_in(instr, pc, ctl);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (id_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: pc=%h never accepted", pc);
    end
    drive_phase();
    if_valid = 1'b0;
  endtask

  // Monitor: every ID/EX transfer is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst && ex_valid && ex_ready) begin
      mon_act = {ex_a, ex_b, ex_imm, ex_jtarget, ex_pc, ex_dst,
                 ex_reg_write, ex_mem_read, ex_mem_write, ex_link};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_txn: got=%h expected=none", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL txn pc=%h: got=%h expected=%h", mon_exp.pc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_valid = 1'b1; if_instr = 16'hDB04; if_pc = '0;
    {ctl_reg_dst, ctl_five_imm, ctl_zero_ext, ctl_reg_write, ctl_mem_read, ctl_mem_write} = 6'b100100;
    flush = 1'b0; wb_we = 1'b0; wb_reg = '0; wb_data = '0; ex_ready = 1'b1;

    // Reset held with a valid instruction present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_ready", 32'(id_ready), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_a",     32'(ex_a),     32'd0);
    chk("rst_ex_imm",   32'(ex_imm),   32'd0);
    chk("rst_ex_dst",   32'(ex_dst),   32'd0);
    chk("rst_err",      32'(err),      32'd0);
    drive_phase();
    rst = 1'b1; if_valid = 1'b0;

    // WB->ID bypass on R3.
    wb_we = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234;
    issue(16'hDB04, 16'h0010, 6'b100100,
          mk(16'h1234, 16'h0000, 16'h0004, 16'h0304, 16'h0010, 3'd1, 1, 0, 0, 0));
    wb_we = 1'b0;
    @(negedge clk);
    chk("nofwd_old_value", 32'(ex_a_f0), 32'h0000);
    drive_phase();
    issue(16'hDB04, 16'h0012, 6'b100100,
          mk(16'h1234, 16'h0000, 16'h0004, 16'h0304, 16'h0012, 3'd1, 1, 0, 0, 0));
    @(negedge clk);
    chk("nofwd_next_instr", 32'(ex_a_f0), 32'h1234);
    drive_phase();

    // Load-use stall: LD R2 followed by a reader of R2 in [7:5].
    issue(16'h8845, 16'h0020, 6'b010110,
          mk(16'h0000, 16'h0000, 16'h0005, 16'h0045, 16'h0020, 3'd2, 1, 1, 0, 0));
    set_in(16'hDB50, 16'h0022, 6'b100100);
    @(negedge clk);
    chk("lu_id_ready_low", 32'(id_ready), 32'd0);
    chk("lu_ld_in_ex",     32'(ex_valid), 32'd1);
    @(negedge clk);
    chk("lu_bubble",       32'(ex_valid), 32'd0);
    chk("lu_id_ready_up",  32'(id_ready), 32'd1);
    if (id_ready)
      sb.push_back(mk(16'h1234, 16'h0000, 16'h0050, 16'h0350, 16'h0022, 3'd4, 1, 0, 0, 0));
    drive_phase();
    if_valid = 1'b0;

    // Backpressure: hold zero-extended 5-bit-imm instruction for three cycles.
    issue(16'h53B6, 16'h0030, 6'b011100,
          mk(16'h1234, 16'h0000, 16'h0016, 16'h03B6, 16'h0030, 3'd5, 1, 0, 0, 0));
    ex_ready = 1'b0;
    set_in(16'hC1F0, 16'h0032, 6'b000100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ex_valid", 32'(ex_valid), 32'd1);
      chk("bp_id_ready", 32'(id_ready), 32'd0);
      chk("bp_ex_a",     32'(ex_a),     32'h1234);
      chk("bp_ex_imm",   32'(ex_imm),   32'h0016);
      chk("bp_ex_dst",   32'(ex_dst),   32'd5);
    end
    drive_phase();
    ex_ready = 1'b1;
    issue(16'hC1F0, 16'h0032, 6'b000100,
          mk(16'h0000, 16'h0000, 16'hFFF0, 16'h01F0, 16'h0032, 3'd1, 1, 0, 0, 0));

    // Jumps and STU destination selection.
    issue(16'h3B80, 16'h0040, 6'b000000,
          mk(16'h1234, 16'h0000, 16'hFF80, 16'hFF80, 16'h0040, 3'd7, 1, 0, 0, 1));
    issue(16'h3400, 16'h0042, 6'b000000,
          mk(16'h0000, 16'h0000, 16'h0000, 16'hFC00, 16'h0042, 3'd7, 1, 0, 0, 1));
    issue(16'h9E23, 16'h0044, 6'b010101,
          mk(16'h0000, 16'h0000, 16'h0003, 16'hFE23, 16'h0044, 3'd6, 1, 0, 1, 0));

    // Flush with a valid incoming instruction and a concurrent WB write to R6.
    issue(16'hDB04, 16'h0050, 6'b100100,
          mk(16'h1234, 16'h0000, 16'h0004, 16'h0304, 16'h0050, 3'd1, 1, 0, 0, 0));
    flush = 1'b1; wb_we = 1'b1; wb_reg = 3'd6; wb_data = 16'hBEEF;
    set_in(16'hDB04, 16'h0054, 6'b100100);
    drive_phase();
    flush = 1'b0; wb_we = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_kill", 32'(ex_valid), 32'd0);
    chk("err_clear",  32'(err),      32'd0);
    drive_phase();
    issue(16'hDE60, 16'h0052, 6'b100100,
          mk(16'hBEEF, 16'h1234, 16'h0060, 16'hFE60, 16'h0052, 3'd0, 1, 0, 0, 0));

    // Sticky error on a load+store accept, cleared only by reset.
    issue(16'h8845, 16'h0060, 6'b010011,
          mk(16'h0000, 16'h0000, 16'h0005, 16'h0045, 16'h0060, 3'd2, 0, 1, 1, 0));
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    drive_phase();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_id_ready", 32'(id_ready), 32'd0);
    drive_phase();
    @(negedge clk);
    chk("rst2_err",      32'(err),      32'd0);
    chk("rst2_ex_valid", 32'(ex_valid), 32'd0);
    drive_phase();
    rst = 1'b1;
    issue(16'hDB04, 16'h0070, 6'b100100,
          mk(16'h0000, 16'h0000, 16'h0004, 16'h0304, 16'h0070, 3'd1, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
